// File: rtl/instr_fetch.sv
// Instruction fetch stage: a PC register, a single output register toward decode,
// j-type predecode for next-PC, redirect flush, and a handshake counter.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] fetch_count
);

    // Keeps the PC word-aligned and wrapped inside the instruction memory.
    localparam logic [31:0] PC_MASK = 32'(MEM_WORDS * 4 - 1) & ~32'h3;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        advance;
    logic        handshake;

    assign imem_addr = pc;
    assign handshake = if_valid && if_ready;
    assign advance   = (state == FETCH) && (!if_valid || if_ready) && !redirect_valid;

    always_comb begin
        pc_plus4 = pc + 32'd4;
        next_pc  = pc_plus4;
        if (imem_rdata[31:26] == 6'b000010)
            next_pc = {pc_plus4[31:28], imem_rdata[25:0], 2'b00};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC & PC_MASK;
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            fetch_count <= '0;
        end else begin
            state <= run ? FETCH : IDLE;

            if (handshake)
                fetch_count <= fetch_count + 32'd1;

            // Redirect wins over capture and consumption in either state.
            if (redirect_valid) begin
                pc       <= redirect_target & PC_MASK;
                if_valid <= 1'b0;
            end else if (advance) begin
                if_instr <= imem_rdata;
                if_pc    <= pc;
                if_valid <= 1'b1;
                pc       <= next_pc & PC_MASK;
            end else if (handshake) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL expose parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL expose parameter MEM_WORDS, 256, instruction-memory depth in 32-bit words (power of two); PC space = MEM_WORDS*4 bytes.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port run  input  1  fetch enable.
REQ-006 SHALL have port imem_addr  output  32  byte address to instruction memory; combinational copy of PC register.
REQ-007 SHALL have port imem_rdata  input  32  instruction word returned combinationally by memory for imem_addr.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect from a later stage.
REQ-009 SHALL have port redirect_target  input  32  redirect byte address.
REQ-010 SHALL have port if_valid  output  1  output register holds an instruction.
REQ-011 SHALL have port if_ready  input  1  decode accepts the instruction this cycle.
REQ-012 SHALL have port if_instr  output  32  fetched instruction.
REQ-013 SHALL have port if_pc  output  32  address of if_instr.
REQ-014 SHALL have port fetch_count  output  32  count of completed if_valid&&if_ready handshakes.

Function
REQ-015 SHALL implement FSM states IDLE and FETCH; IDLE->FETCH on clk edge with run=1; FETCH->IDLE on clk edge with run=0.
REQ-016 SHALL define advance = (state==FETCH) && (!if_valid || if_ready) && !redirect_valid.
REQ-017 On advance SHALL capture if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=next_pc; latency from PC to output = 1 cycle.
REQ-018 next_pc SHALL be {pc_plus4[31:28], imem_rdata[25:0], 2'b00} when imem_rdata[31:26]==6'b000010 (j predecode), else pc+4.
REQ-019 All PC updates SHALL be masked: pc <= value & (MEM_WORDS*4-1) & ~32'h3 (wrap-around at top of memory, bits[1:0] forced 0).
REQ-020 Backpressure: if_valid=1 && if_ready=0 && no redirect SHALL hold pc, if_instr, if_pc, if_valid unchanged.
REQ-021 Without advance, if_valid SHALL clear when if_valid && if_ready (consumed, not refilled).
REQ-022 redirect_valid=1 SHALL have priority over all other events in both states: pc<=masked redirect_target, if_valid<=0 (flush), no capture that cycle.
REQ-023 fetch_count SHALL increment by 1 on every edge where if_valid && if_ready, including cycles with simultaneous redirect or run=0; wraps at 2^32.
REQ-024 In IDLE SHALL perform no capture; an unconsumed if_valid instruction SHALL remain until handshaken or redirected.
REQ-025 Redirect in the same cycle as a handshake: handshake completes (counted), next cycle if_valid=0, then first capture from the target address.

Reset
REQ-026 reset=1 SHALL asynchronously force state=IDLE, pc=RESET_PC masked, if_valid=0, if_instr=0, if_pc=0, fetch_count=0.
REQ-027 reset asserted mid-operation SHALL discard any held instruction and pending redirect; no output may change on the first clk edge after release other than state (IDLE->FETCH if run=1).
REQ-028 After release with run=1, if_valid SHALL first assert after the second rising clk edge.

Verification
REQ-029 Memory holding 0x20080002 at 0x0 and 0x200A0002 at 0x4, run=1, if_ready=1 -> after second edge if_instr=0x20080002, if_pc=0x0; next edge if_instr=0x200A0002, if_pc=0x4, fetch_count=1.
REQ-030 Word at 0x20 = 0x08000006 -> next if_pc=0x18; word at 0x24 = 0x08000009 -> if_pc stays 0x24 every cycle (self-loop) and fetch_count increments each cycle.
REQ-031 if_ready=0 for 5 cycles with if_valid=1 -> if_instr, if_pc, imem_addr constant; fetch_count unchanged; resumes at the held if_pc+4 once if_ready=1.
REQ-032 redirect_valid=1, redirect_target=0x1003, concurrent handshake -> next cycle if_valid=0, imem_addr=0x000, fetch_count+1; following cycle if_pc=0x000.
REQ-033 Sequential fetch at pc=0x3FC (MEM_WORDS=256) -> next imem_addr=0x000.
REQ-034 reset pulsed mid-stream with if_valid=1 -> if_valid=0 and fetch_count=0 immediately (no clk edge); fetch restarts at RESET_PC.
